debounce_timer_arbiter: RTL and testbench

DEBOUNCE_TIMER_ARBITER -- requirements
Module: debounce_timer_arbiter

---
 rtl/debounce_timer_arbiter_if.sv | 24 ++
 rtl/debounce_timer_arbiter.sv | 113 +++++++++++
 tb/tb_debounce_timer_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/debounce_timer_arbiter_if.sv
// Client-side bundle for the shared debounce timer.
// Ports: timer_clr (client->arbiter), timer_done/busy/grant_id (arbiter->client).
interface debounce_timer_arbiter_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0] timer_clr;
   logic [N_CH-1:0] timer_done;
   logic            busy;
   logic [1:0]      grant_id;

   modport master (
      output timer_clr,
      input  timer_done,
      input  busy,
      input  grant_id
   );

   modport slave (
      input  timer_clr,
      output timer_done,
      output busy,
      output grant_id
   );
endinterface

// File: rtl/debounce_timer_arbiter.sv
// One interval counter shared round-robin between N_CH debounce clients.
// Ports: clk, reset (async, active high), bus (slave: clr in; done/busy/grant out).
module debounce_timer_arbiter #(
   parameter int N_CH   = 4,
   parameter int PERIOD = 250000,
   parameter int CNT_W  = 18
) (
   input logic clk,
   input logic reset,
   debounce_timer_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   state_t          state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]      rr_q, rr_d;
   logic [1:0]      gnt_q, gnt_d;
   logic [N_CH-1:0] served_q, served_d;
   logic [N_CH-1:0] req;
   logic [1:0]      pick;
   logic [1:0]      idx;
   logic            hit;
   logic            abort;

   // A client already served stays masked until it goes idle again.
   assign req   = ~bus.timer_clr & ~served_q;
   assign abort = bus.timer_clr[gnt_q];

   // Round-robin scan from rr_q; 2-bit index wraps mod N_CH.
   always_comb begin
      hit  = 1'b0;
      pick = rr_q;
      idx  = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = rr_q + 2'(k);
         if (!hit && req[idx]) begin
            hit  = 1'b1;
            pick = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rr_q     <= '0;
         gnt_q    <= '0;
         served_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_q     <= rr_d;
         gnt_q    <= gnt_d;
         served_q <= served_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rr_d     = rr_q;
      gnt_d    = gnt_q;
      served_d = served_q;
      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (hit) begin
               state_d = COUNT;
               gnt_d   = pick;
            end
         end
         COUNT: begin
            // Abort wins over terminal count.
            if (abort) begin
               state_d = IDLE;
               cnt_d   = '0;
               rr_d    = gnt_q + 2'd1;
            end else if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d         = IDLE;
            cnt_d           = '0;
            rr_d            = gnt_q + 2'd1;
            served_d[gnt_q] = 1'b1;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
      // An idle client always re-arms, even on the DONE edge.
      served_d = served_d & ~bus.timer_clr;
   end

   always_comb begin
      bus.timer_done = '0;
      if (state_q == DONE)
         bus.timer_done = {{(N_CH-1){1'b0}}, 1'b1} << gnt_q;
      bus.busy     = (state_q != IDLE);
      bus.grant_id = gnt_q;
   end
endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Directed plus random bench for debounce_timer_arbiter with a reference model.
// Ports: none; drives clk, reset and the client side of the interface.
module tb_debounce_timer_arbiter;
   localparam int P = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   debounce_timer_arbiter_if #(.N_CH(4)) bus();

   debounce_timer_arbiter #(
      .N_CH(4),
      .PERIOD(P),
      .CNT_W(18)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;

   bit         m_active;
   int         m_age;
   int         m_gid;
   int         m_ptr;
   logic [3:0] m_served;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 1'b0;
      m_age    = 0;
      m_gid    = 0;
      m_ptr    = 0;
      m_served = 4'b0000;
   endtask

   function automatic logic [31:0] exp_done();
      if (m_active && m_age == P) return 32'd1 << m_gid;
      return 32'd0;
   endfunction

   task automatic model_edge(input logic [3:0] c);
      logic [3:0] ns;
      bit found;
      int ch;
      ns = m_served;
      if (m_active && m_age == P) begin
         ns[m_gid] = 1'b1;
         m_active  = 1'b0;
         m_ptr     = (m_gid + 1) % 4;
      end else if (m_active && c[m_gid]) begin
         m_active = 1'b0;
         m_ptr    = (m_gid + 1) % 4;
      end else if (m_active) begin
         m_age++;
      end else begin
         found = 1'b0;
         for (int k = 0; k < 4; k++) begin
            ch = (m_ptr + k) % 4;
            if (!found && !c[ch] && !m_served[ch]) begin
               found    = 1'b1;
               m_active = 1'b1;
               m_age    = 0;
               m_gid    = ch;
            end
         end
      end
      m_served = ns & ~c;
   endtask

   task automatic check_outputs(input string where);
      chk({where, ":busy"}, 32'(bus.busy), 32'(m_active));
      chk({where, ":done"}, 32'(bus.timer_done), exp_done());
      chk({where, ":grant"}, 32'(bus.grant_id), 32'(m_gid));
   endtask

   task automatic step(input logic [3:0] c);
      bus.timer_clr = c;
      @(posedge clk);
      model_edge(c);
      #1;
      check_outputs("step");
   endtask

   // Reset pulse strictly between clock edges.
   task automatic async_reset();
      #1 reset = 1'b1;
      #1;
      chk("arst:busy", 32'(bus.busy), 32'd0);
      chk("arst:done", 32'(bus.timer_done), 32'd0);
      chk("arst:grant", 32'(bus.grant_id), 32'd0);
      #1 reset = 1'b0;
      model_reset();
   endtask

   function automatic int onehot_idx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   initial begin
      int order_exp[4];
      int k;
      int last;
      int ndone;
      logic [3:0] c;
      logic [3:0] prev;

      order_exp = '{0, 1, 2, 3};
      bus.timer_clr = 4'b1111;
      model_reset();
      #12;
      check_outputs("reset");
      reset = 1'b0;
      step(4'b1111);

      step(4'b1011);
      chk("single:grant", 32'(bus.grant_id), 32'd2);
      chk("single:busy", 32'(bus.busy), 32'd1);
      for (int n = 0; n < P - 1; n++) step(4'b1011);
      chk("single:nodone", 32'(bus.timer_done), 32'd0);
      step(4'b1011);
      chk("single:done", 32'(bus.timer_done), 32'b0100);
      step(4'b1011);
      chk("single:idle", 32'(bus.busy), 32'd0);
      step(4'b1111);

      @(negedge clk);
      async_reset();
      k = 0;
      last = 0;
      prev = 4'b0000;
      for (int n = 0; n < 4 * (P + 2) + 2; n++) begin
         c = prev;
         step(c);
         if (bus.timer_done != 4'b0000) begin
            if (k < 4)
               chk("all:order", 32'(onehot_idx(bus.timer_done)),
                   32'(order_exp[k]));
            if (k > 0) chk("all:gap", 32'(n - last), 32'(P + 2));
            last = n;
            k++;
         end
         prev = bus.timer_done;
      end
      chk("all:count", 32'(k), 32'd4);
      step(4'b1111);
      step(4'b1111);

      step(4'b0101);
      chk("abort:grant1", 32'(bus.grant_id), 32'd1);
      step(4'b0101);
      step(4'b0101);
      step(4'b0111);
      chk("abort:idle", 32'(bus.busy), 32'd0);
      chk("abort:nodone", 32'(bus.timer_done), 32'd0);
      step(4'b0111);
      chk("abort:grant3", 32'(bus.grant_id), 32'd3);
      chk("abort:busy3", 32'(bus.busy), 32'd1);
      for (int n = 0; n < P + 2; n++) step(4'b0111);
      step(4'b1111);

      ndone = 0;
      for (int n = 0; n < 3 * (P + 2); n++) begin
         step(4'b1110);
         if (bus.timer_done[0]) ndone++;
      end
      chk("mask:held", 32'(ndone), 32'd1);
      step(4'b1111);
      ndone = 0;
      for (int n = 0; n < P + 2; n++) begin
         step(4'b1110);
         if (bus.timer_done[0]) ndone++;
      end
      chk("mask:rearm", 32'(ndone), 32'd1);
      step(4'b1111);
      step(4'b1111);

      step(4'b0110);
      chk("fair:grant3", 32'(bus.grant_id), 32'd3);
      step(4'b1111);
      step(4'b1111);

      step(4'b1110);
      step(4'b1110);
      step(4'b1110);
      async_reset();
      ndone = 0;
      for (int n = 0; n < P + 3; n++) begin
         step(4'b1111);
         if (bus.timer_done != 4'b0000) ndone++;
      end
      chk("arst:nopulse", 32'(ndone), 32'd0);

      c = 4'b1111;
      for (int n = 0; n < 600; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(7) == 0) c[i] = ~c[i];
         step(c);
         if ($urandom_range(149) == 0) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
